pkt_sender: RTL

Packet source that drives the sorter's input stream (`data_i`/`sop_i`/`eop_i`/`val_i`) and obeys its `busy_o`. Software or bench logic loads up to 2^AWIDTH words into an internal buffer. A start strobe then emits them as one contiguous packet: `sop` on the first word, `eop` on the last. The block sits directly upstream of the sorter, on the same clock.

---
 rtl/sorting_pkg.sv | 10 +
 rtl/pkt_sender_if.sv | 20 ++
 rtl/pkt_sender_tx_buffer.sv | 34 +++
 rtl/pkt_sender.sv | 125 ++++++++++++
 4 files changed

// File: rtl/sorting_pkg.sv
// Shared types for the packet sender and sorter datapath.
package sorting_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RDY,
        SEND
    } tx_state_t;

endpackage

// File: rtl/pkt_sender_if.sv
// Packet stream toward the sorter, with its back-pressure line.
interface pkt_sender_if #(
    parameter int DWIDTH = 8
);
    logic [DWIDTH-1:0] data;
    logic              sop;
    logic              eop;
    logic              val;
    logic              busy;

    modport master (
        output data, sop, eop, val,
        input  busy
    );

    modport slave (
        input  data, sop, eop, val,
        output busy
    );
endinterface

// File: rtl/pkt_sender_tx_buffer.sv
// Packet word store: synchronous write, registered read.
module tx_buffer #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [DWIDTH-1:0] rdata_o
);
    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/pkt_sender.sv
// Buffers written words and replays them as one sop..eop packet.
module pkt_sender
    import sorting_pkg::*;
#(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    input  logic              wr_en_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              ovf_o,
    pkt_sender_if.master      tx
);
    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] FULL = (AWIDTH + 1)'(DEPTH);

    tx_state_t         state_q, state_d;
    logic [AWIDTH:0]   len_q, len_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic              val_q, val_d;
    logic              busy_q;
    logic              ovf_q, ovf_d;
    logic              we;
    logic [DWIDTH-1:0] rdata;
    logic [AWIDTH-1:0] wr_ptr;

    // Words are packed from 0, so the fill count doubles as write pointer.
    assign wr_ptr = len_q[AWIDTH-1:0];

    tx_buffer #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_buf (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .we_i    (we),
        .waddr_i (wr_ptr),
        .wdata_i (wr_data_i),
        .raddr_i (rd_ptr_d),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rd_ptr_d = rd_ptr_q;
        data_d   = '0;
        sop_d    = 1'b0;
        eop_d    = 1'b0;
        val_d    = 1'b0;
        ovf_d    = 1'b0;
        we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wr_en_i) begin
                    if (len_q == FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        we    = 1'b1;
                        len_d = len_q + 1'b1;
                    end
                end
                if (start_i && (len_d != '0)) begin
                    state_d = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (!tx.busy) begin
                    state_d  = SEND;
                    rd_ptr_d = '0;
                end
            end
            SEND: begin
                val_d    = 1'b1;
                data_d   = rdata;
                sop_d    = (rd_ptr_q == '0);
                eop_d    = ({1'b0, rd_ptr_q} == len_q - 1'b1);
                rd_ptr_d = rd_ptr_q + 1'b1;
                if (eop_d) begin
                    state_d  = IDLE;
                    len_d    = '0;
                    rd_ptr_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q  <= IDLE;
            len_q    <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            val_q    <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            val_q    <= val_d;
            busy_q   <= (state_q != IDLE);
            ovf_q    <= ovf_d;
        end
    end

    assign tx.data = data_q;
    assign tx.sop  = sop_q;
    assign tx.eop  = eop_q;
    assign tx.val  = val_q;
    assign busy_o  = busy_q;
    assign ovf_o   = ovf_q;
endmodule
